// File: rtl/ctr_pkg.sv
// rtl/ctr_pkg.sv - shared types and constants for the programmable modulo counter
package ctr_pkg;

  localparam int CTR_MODE_W = 2;

  typedef enum logic [CTR_MODE_W-1:0] {
    CTR_WRAP    = 2'd0,
    CTR_SAT     = 2'd1,
    CTR_ONESHOT = 2'd2,
    CTR_RSVD    = 2'd3
  } ctr_mode_e;

endpackage

// File: rtl/prog_mod_counter_if.sv
// rtl/prog_mod_counter_if.sv - control and status bundle of the programmable modulo counter
interface prog_mod_counter_if
  import ctr_pkg::*;
#(
  parameter int WIDTH = 6
);

  logic                  en;
  logic                  up_dn;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic [WIDTH-1:0]      limit;
  logic [CTR_MODE_W-1:0] mode;
  logic                  clr_ovf;
  logic [WIDTH-1:0]      count;
  logic                  tc;
  logic                  ovf_sticky;
  logic                  done;

  modport master (
    output en, up_dn, load, load_val, limit, mode, clr_ovf,
    input  count, tc, ovf_sticky, done
  );

  modport slave (
    input  en, up_dn, load, load_val, limit, mode, clr_ovf,
    output count, tc, ovf_sticky, done
  );

endinterface

// File: rtl/prog_ctr_step.sv
// rtl/prog_ctr_step.sv - next-value and terminal-event logic for one counter step
module prog_ctr_step
  import ctr_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] limit,
  input  logic             up_dn,
  input  ctr_mode_e        mode,
  output logic [WIDTH-1:0] next_count,
  output logic             is_terminal,
  output logic             set_done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_comb begin
    next_count  = count;
    is_terminal = 1'b0;
    set_done    = 1'b0;
    if (up_dn) begin
      // >= rather than == so a value loaded above limit still terminates
      is_terminal = (count >= limit);
      if (!is_terminal) begin
        next_count = count + ONE;
      end else begin
        case (mode)
          CTR_SAT:     next_count = count;
          CTR_ONESHOT: begin
            next_count = count;
            set_done   = 1'b1;
          end
          default:     next_count = '0;
        endcase
      end
    end else begin
      is_terminal = (count == '0);
      if (!is_terminal) begin
        next_count = count - ONE;
      end else begin
        case (mode)
          CTR_SAT:     next_count = '0;
          CTR_ONESHOT: begin
            next_count = '0;
            set_done   = 1'b1;
          end
          default:     next_count = limit;
        endcase
      end
    end
  end

endmodule

// File: rtl/prog_mod_counter.sv
// rtl/prog_mod_counter.sv - programmable up/down counter with wrap, saturate and one-shot modes
module prog_mod_counter
  import ctr_pkg::*;
#(
  parameter int               WIDTH     = 6,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic               clk,
  input logic               reset,
  prog_mod_counter_if.slave bus
);

  logic [WIDTH-1:0] count_q;
  logic             tc_q;
  logic             ovf_q;
  logic             done_q;
  logic [WIDTH-1:0] next_count;
  logic             is_terminal;
  logic             set_done;
  logic             step;

  prog_ctr_step #(.WIDTH(WIDTH)) u_step (
    .count       (count_q),
    .limit       (bus.limit),
    .up_dn       (bus.up_dn),
    .mode        (ctr_mode_e'(bus.mode)),
    .next_count  (next_count),
    .is_terminal (is_terminal),
    .set_done    (set_done)
  );

  assign step = bus.en && !bus.load && !done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RESET_VAL;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      // clear first so a same-edge terminal event below takes precedence
      if (bus.clr_ovf) begin
        ovf_q <= 1'b0;
      end
      if (bus.load) begin
        count_q <= bus.load_val;
        done_q  <= 1'b0;
      end else if (step) begin
        count_q <= next_count;
        if (is_terminal) begin
          tc_q  <= 1'b1;
          ovf_q <= 1'b1;
        end
        if (set_done) begin
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.count      = count_q;
  assign bus.tc         = tc_q;
  assign bus.ovf_sticky = ovf_q;
  assign bus.done       = done_q;

endmodule
